// File: rtl/npu_energy_csr_responder_pkg.sv
// Shared definitions for the NPU energy/DVFS CSR responder: register map,
// responder FSM states and threshold clamping.
package npu_energy_csr_responder_pkg;

  localparam logic [7:0] CSR_ENERGY_LO = 8'h60;
  localparam logic [7:0] CSR_ENERGY_HI = 8'h64;
  localparam logic [7:0] CSR_UTIL_HIGH = 8'hA0;
  localparam logic [7:0] CSR_UTIL_LOW  = 8'hA4;
  localparam logic [7:0] CSR_STATUS    = 8'hA8;

  localparam logic [7:0] PCT_MAX = 8'd100;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WAIT_REL
  } csr_rsp_state_e;

  // Thresholds are percentages, so anything above 100 is pinned to 100.
  function automatic logic [7:0] clamp_pct(input logic [31:0] wdata);
    return (wdata > {24'b0, PCT_MAX}) ? PCT_MAX : wdata[7:0];
  endfunction

endpackage

// File: rtl/npu_energy_csr_responder_if.sv
// CSR request/response bus between the host initiator and the responder.
interface npu_energy_csr_responder_if;

  logic        csr_valid;
  logic        csr_write;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ready;

  modport master (
    output csr_valid, csr_write, csr_addr, csr_wdata,
    input  csr_rdata, csr_ready
  );

  modport slave (
    input  csr_valid, csr_write, csr_addr, csr_wdata,
    output csr_rdata, csr_ready
  );

endinterface

// File: rtl/npu_energy_csr_responder_accumulator.sv
// Saturating energy accumulator with a snapshot register so a 64-bit value
// can be read coherently as two 32-bit words (lo read captures, hi read
// returns the captured upper half).
module npu_energy_csr_responder_accumulator #(
  parameter int ENERGY_W = 64,
  parameter int INC_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_valid,
  input  logic [INC_W-1:0]  inc,
  input  logic              snap_req,
  output logic [31:0]       acc_lo,
  output logic [31:0]       snap_hi
);

  logic [ENERGY_W-1:0] acc;
  logic [ENERGY_W-1:0] snap;
  logic [ENERGY_W-1:0] acc_nxt;
  logic [ENERGY_W-1:0] snap_nxt;

  // Add with clamp at all-ones; the accumulator must never wrap.
  function automatic logic [ENERGY_W-1:0] sat_add(input logic [ENERGY_W-1:0] a,
                                                  input logic [INC_W-1:0]    b);
    logic [ENERGY_W:0] sum;
    sum = {1'b0, a} + {{(ENERGY_W + 1 - INC_W){1'b0}}, b};
    return sum[ENERGY_W] ? '1 : sum[ENERGY_W-1:0];
  endfunction

  // Next-state: snapshot takes the pre-increment value of this cycle.
  always_comb begin
    acc_nxt  = inc_valid ? sat_add(acc, inc) : acc;
    snap_nxt = snap_req ? acc : snap;
  end

  // Both registers are reloaded every cycle from their next-state value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      snap <= '0;
    end else begin
      acc  <= acc_nxt;
      snap <= snap_nxt;
    end
  end

  assign acc_lo  = acc[31:0];
  assign snap_hi = snap[63:32];

endmodule

// File: rtl/npu_energy_csr_responder.sv
// CSR responder inside the NPU top: serves the energy accumulator and the
// DVFS utilisation thresholds over a valid/ready CSR bus. Each request is
// answered with a one-cycle ready pulse; WAIT_REL blocks re-acceptance until
// the initiator drops valid.
module npu_energy_csr_responder
  import npu_energy_csr_responder_pkg::*;
#(
  parameter int ENERGY_W      = 64,
  parameter int INC_W         = 16,
  parameter int UTIL_HIGH_RST = 90,
  parameter int UTIL_LOW_RST  = 30
) (
  input  logic                        clk,
  input  logic                        reset_n,
  npu_energy_csr_responder_if.slave   csr,
  input  logic                        energy_inc_valid,
  input  logic [INC_W-1:0]            energy_inc,
  output logic [7:0]                  util_high_pct,
  output logic [7:0]                  util_low_pct,
  output logic                        thresh_update
);

  csr_rsp_state_e state;
  logic [1:0]     status;
  logic [31:0]    acc_lo;
  logic [31:0]    snap_hi;
  logic           accept;
  logic           snap_req;
  logic [7:0]     wr_pct;
  logic [31:0]    rd_data;
  logic           rd_bad;

  assign accept   = (state == IDLE) && csr.csr_valid;
  assign snap_req = accept && !csr.csr_write && (csr.csr_addr == CSR_ENERGY_LO);
  assign wr_pct   = clamp_pct(csr.csr_wdata);

  npu_energy_csr_responder_accumulator #(
    .ENERGY_W (ENERGY_W),
    .INC_W    (INC_W)
  ) u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc_valid (energy_inc_valid),
    .inc       (energy_inc),
    .snap_req  (snap_req),
    .acc_lo    (acc_lo),
    .snap_hi   (snap_hi)
  );

  // Read data mux; anything not in the map reads as zero and flags bad_addr.
  always_comb begin
    rd_data = '0;
    rd_bad  = 1'b0;
    case (csr.csr_addr)
      CSR_ENERGY_LO: rd_data = acc_lo;
      CSR_ENERGY_HI: rd_data = snap_hi;
      CSR_UTIL_HIGH: rd_data = {24'b0, util_high_pct};
      CSR_UTIL_LOW:  rd_data = {24'b0, util_low_pct};
      CSR_STATUS:    rd_data = {30'b0, status};
      default:       rd_bad  = 1'b1;
    endcase
  end

  // Responder FSM: the request is executed on the accepting edge so data,
  // threshold outputs and the update pulse are all visible in the RESP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      csr.csr_ready <= 1'b0;
      csr.csr_rdata <= '0;
      thresh_update <= 1'b0;
      util_high_pct <= 8'(UTIL_HIGH_RST);
      util_low_pct  <= 8'(UTIL_LOW_RST);
      status        <= '0;
    end else begin
      csr.csr_ready <= 1'b0;
      thresh_update <= 1'b0;
      case (state)
        IDLE: begin
          if (csr.csr_valid) begin
            state         <= RESP;
            csr.csr_ready <= 1'b1;
            if (!csr.csr_write) begin
              csr.csr_rdata <= rd_data;
              if (rd_bad) status[1] <= 1'b1;
            end else begin
              csr.csr_rdata <= '0;
              case (csr.csr_addr)
                CSR_UTIL_HIGH: begin
                  if (util_low_pct < wr_pct) begin
                    util_high_pct <= wr_pct;
                    thresh_update <= (wr_pct != util_high_pct);
                  end else begin
                    status[0] <= 1'b1;
                  end
                end
                CSR_UTIL_LOW: begin
                  if (wr_pct < util_high_pct) begin
                    util_low_pct  <= wr_pct;
                    thresh_update <= (wr_pct != util_low_pct);
                  end else begin
                    status[0] <= 1'b1;
                  end
                end
                CSR_STATUS: status <= status & ~csr.csr_wdata[1:0];
                default:    status[1] <= 1'b1;
              endcase
            end
          end
        end
        RESP:     state <= WAIT_REL;
        WAIT_REL: if (!csr.csr_valid) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
